// File: rtl/y86_mem_responder_pkg.sv
// Shared widths, byte type and loader state encoding for the y86 memory responder.
package y86_mem_responder_pkg;
  localparam int WORD_W    = 32;
  localparam int INSTBUS_W = 48;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_e;
endpackage

// File: rtl/y86_mem_loader.sv
// Byte-serial program loader: start/length capture, valid/ready handshake, done pulse.
import y86_mem_responder_pkg::*;

module y86_mem_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start_i,
  input  logic [ADDR_W-1:0] load_base_i,
  input  logic [ADDR_W:0]   load_len_i,
  input  logic              load_valid_i,
  output logic              load_ready_o,
  output logic              load_done_o,
  output logic              wr_en_o,
  output logic [ADDR_W:0]   wr_addr_o,
  output ld_state_e         state_o
);
  // state | meaning
  // LD_IDLE | CPU may run; waiting for load_start_i
  // LD_LOAD | accepting image bytes, CPU held in reset
  // LD_DONE | one-cycle done pulse, CPU still in reset
  ld_state_e         state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ready, done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LD_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      LD_IDLE: begin
        if (load_start_i) begin
          ptr_d   = {1'b0, load_base_i};
          cnt_d   = load_len_i;
          state_d = (load_len_i == '0) ? LD_DONE : LD_LOAD;
        end
      end
      LD_LOAD: begin
        ready = 1'b1;
        if (load_valid_i) begin
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == (ADDR_W+1)'(1)) state_d = LD_DONE;
        end
      end
      LD_DONE: begin
        done    = 1'b1;
        state_d = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  // Reset is synchronous, so mask handshake outputs while rst is still high.
  assign load_ready_o = ready & ~rst;
  assign load_done_o  = done & ~rst;
  assign wr_en_o      = ready & load_valid_i & ~rst;
  assign wr_addr_o    = ptr_q;
  assign state_o      = state_q;
endmodule

// File: rtl/y86_mem_responder.sv
// Byte RAM serving the 6-byte fetch port and the 32-bit data port, plus program loader.
import y86_mem_responder_pkg::*;

module y86_mem_responder #(
  parameter int ADDR_W = 12,
  parameter int WORD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          rom_addr_i,
  output logic [INSTBUS_W-1:0] rom_data_o,
  input  logic                 mem_read_i,
  input  logic                 mem_write_i,
  input  logic [31:0]          mem_addr_i,
  input  logic [WORD_W-1:0]    mem_data_i,
  output logic [WORD_W-1:0]    mem_data_o,
  output logic                 mem_err_o,
  input  logic                 load_start_i,
  input  logic [ADDR_W-1:0]    load_base_i,
  input  logic [ADDR_W:0]      load_len_i,
  input  logic                 load_valid_i,
  input  logic [7:0]           load_byte_i,
  output logic                 load_ready_o,
  output logic                 load_done_o,
  output logic                 cpu_rst_o
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = WORD_W / 8;
  localparam int FB    = INSTBUS_W / 8;

  byte_t             mem_q [DEPTH];
  logic              err_q, err_d;
  logic              ld_wr_en;
  logic [ADDR_W:0]   ld_wr_addr;
  ld_state_e         ld_state;
  logic              ld_idle;
  logic [ADDR_W-1:0] a_lo;
  logic [ADDR_W:0]   a_last;
  logic              data_oor, rd_ok, cpu_wr_en, ld_oor;

  y86_mem_loader #(.ADDR_W(ADDR_W)) u_loader (
    .clk          (clk),
    .rst          (rst),
    .load_start_i (load_start_i),
    .load_base_i  (load_base_i),
    .load_len_i   (load_len_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .load_done_o  (load_done_o),
    .wr_en_o      (ld_wr_en),
    .wr_addr_o    (ld_wr_addr),
    .state_o      (ld_state)
  );

  assign ld_idle   = (ld_state == LD_IDLE);
  assign cpu_rst_o = rst | ~ld_idle;

  // Last byte of the word must land inside the array; carry into bit ADDR_W means overflow.
  assign a_lo      = mem_addr_i[ADDR_W-1:0];
  assign a_last    = {1'b0, a_lo} + (ADDR_W+1)'(NB-1);
  assign data_oor  = (mem_addr_i[31:ADDR_W] != '0) | a_last[ADDR_W];
  assign rd_ok     = mem_read_i & ~data_oor;
  assign cpu_wr_en = mem_write_i & ld_idle & ~rst & ~data_oor;
  assign ld_oor    = ld_wr_addr[ADDR_W];

  for (genvar k = 0; k < NB; k++) begin : g_rd
    assign mem_data_o[8*k +: 8] = rd_ok ? mem_q[a_lo + ADDR_W'(k)] : 8'h00;
  end

  for (genvar k = 0; k < FB; k++) begin : g_fetch
    logic [32:0] fa;
    assign fa = {1'b0, rom_addr_i} + 33'(k);
    assign rom_data_o[INSTBUS_W-1-8*k -: 8] =
      (fa[32:ADDR_W] == '0) ? mem_q[fa[ADDR_W-1:0]] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (cpu_wr_en) begin
      for (int k = 0; k < NB; k++) mem_q[a_lo + ADDR_W'(k)] <= mem_data_i[8*k +: 8];
    end
    if (ld_wr_en && !ld_oor) mem_q[ld_wr_addr[ADDR_W-1:0]] <= load_byte_i;
  end

  always_comb begin
    err_d = err_q;
    if (((mem_read_i | mem_write_i) & data_oor) | (ld_wr_en & ld_oor)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign mem_err_o = err_q;
endmodule

// File: tb/tb_y86_mem_responder.sv
// Directed bench for y86_mem_responder: loader, data port, fetch, range errors, reset mid-load.
module tb_y86_mem_responder;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 2**ADDR_W;

  logic              clk;
  logic              rst;
  logic [31:0]       rom_addr_i;
  logic [47:0]       rom_data_o;
  logic              mem_read_i, mem_write_i;
  logic [31:0]       mem_addr_i, mem_data_i, mem_data_o;
  logic              mem_err_o;
  logic              load_start_i;
  logic [ADDR_W-1:0] load_base_i;
  logic [ADDR_W:0]   load_len_i;
  logic              load_valid_i;
  logic [7:0]        load_byte_i;
  logic              load_ready_o, load_done_o, cpu_rst_o;

  int nvec = 0;
  int nerr = 0;

  y86_mem_responder #(.ADDR_W(ADDR_W), .WORD_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .rom_addr_i   (rom_addr_i),
    .rom_data_o   (rom_data_o),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .mem_addr_i   (mem_addr_i),
    .mem_data_i   (mem_data_i),
    .mem_data_o   (mem_data_o),
    .mem_err_o    (mem_err_o),
    .load_start_i (load_start_i),
    .load_base_i  (load_base_i),
    .load_len_i   (load_len_i),
    .load_valid_i (load_valid_i),
    .load_byte_i  (load_byte_i),
    .load_ready_o (load_ready_o),
    .load_done_o  (load_done_o),
    .cpu_rst_o    (cpu_rst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_write_i = 1'b1;
    mem_addr_i  = a;
    mem_data_i  = d;
    step();
    mem_write_i = 1'b0;
  endtask

  task automatic ld_start(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len);
    load_start_i = 1'b1;
    load_base_i  = base;
    load_len_i   = len;
    step();
    load_start_i = 1'b0;
  endtask

  initial begin
    logic [7:0] img [6];
    img[0] = 8'h30; img[1] = 8'hF0; img[2] = 8'h04;
    img[3] = 8'h03; img[4] = 8'h02; img[5] = 8'h01;

    rst = 1'b1; rom_addr_i = '0; mem_read_i = 0; mem_write_i = 0;
    mem_addr_i = '0; mem_data_i = '0; load_start_i = 0; load_base_i = '0;
    load_len_i = '0; load_valid_i = 0; load_byte_i = '0;
    step();
    step();
    chk("rst_cpu_rst", cpu_rst_o, 1'b1);
    chk("rst_ready", load_ready_o, 1'b0);
    chk("rst_done", load_done_o, 1'b0);
    chk("rst_err", mem_err_o, 1'b0);
    rst = 1'b0;
    #1;
    chk("idle_cpu_rst", cpu_rst_o, 1'b0);

    wr(32'h100, 32'h0);
    wr(32'h104, 32'h0);
    wr(32'h010, 32'h0);
    wr(32'h200, 32'hA0A1A2A3);
    wr(32'h204, 32'hB0B1B2B3);

    // 6-byte image at base 0
    ld_start('0, 13'd6);
    for (int i = 0; i < 6; i++) begin
      load_valid_i = 1'b1;
      load_byte_i  = img[i];
      #1;
      chk($sformatf("load_ready_%0d", i), load_ready_o, 1'b1);
      chk($sformatf("load_cpurst_%0d", i), cpu_rst_o, 1'b1);
      chk($sformatf("load_nodone_%0d", i), load_done_o, 1'b0);
      step();
    end
    load_valid_i = 1'b0;
    #1;
    chk("load_done", load_done_o, 1'b1);
    chk("load_done_ready", load_ready_o, 1'b0);
    chk("load_done_cpurst", cpu_rst_o, 1'b1);
    step();
    chk("load_done_gone", load_done_o, 1'b0);
    chk("load_cpurst_fall", cpu_rst_o, 1'b0);
    rom_addr_i = 32'h0;
    #1;
    chk("fetch_0", rom_data_o, 48'h30F004030201);

    // data write, aligned and unaligned reads
    wr(32'h100, 32'h11223344);
    mem_read_i = 1'b1;
    mem_addr_i = 32'h100;
    #1;
    chk("rd_100", mem_data_o, 32'h11223344);
    mem_addr_i = 32'h101;
    #1;
    chk("rd_101", mem_data_o, 32'h00112233);
    mem_read_i = 1'b0;
    #1;
    chk("rd_off", mem_data_o, 32'h0);

    // read-during-write returns old data; fetch also sees old bytes
    mem_read_i  = 1'b1;
    mem_write_i = 1'b1;
    mem_addr_i  = 32'h100;
    mem_data_i  = 32'hAABBCCDD;
    rom_addr_i  = 32'h100;
    #1;
    chk("rdw_old", mem_data_o, 32'h11223344);
    chk("rdw_fetch_old", rom_data_o, 48'h443322110000);
    step();
    mem_write_i = 1'b0;
    #1;
    chk("rdw_new", mem_data_o, 32'hAABBCCDD);
    chk("rdw_fetch_new", rom_data_o, 48'hDDCCBBAA0000);
    mem_read_i = 1'b0;

    // zero-length load
    ld_start(12'h300, 13'd0);
    #1;
    chk("len0_done", load_done_o, 1'b1);
    chk("len0_ready", load_ready_o, 1'b0);
    chk("len0_cpurst", cpu_rst_o, 1'b1);
    step();
    chk("len0_done_gone", load_done_o, 1'b0);
    chk("len0_cpurst_fall", cpu_rst_o, 1'b0);

    // valid gaps stall the count
    ld_start(12'h010, 13'd2);
    load_valid_i = 1'b0;
    #1;
    chk("gap_ready", load_ready_o, 1'b1);
    step();
    load_valid_i = 1'b1; load_byte_i = 8'h5A;
    step();
    load_valid_i = 1'b0;
    step();
    #1;
    chk("gap_nodone", load_done_o, 1'b0);
    load_valid_i = 1'b1; load_byte_i = 8'h6B;
    step();
    load_valid_i = 1'b0;
    #1;
    chk("gap_done", load_done_o, 1'b1);
    step();
    mem_read_i = 1'b1;
    mem_addr_i = 32'h010;
    #1;
    chk("gap_data", mem_data_o, 32'h00006B5A);
    mem_read_i = 1'b0;

    // reset after 3 of 8 bytes
    ld_start(12'h200, 13'd8);
    for (int i = 0; i < 3; i++) begin
      load_valid_i = 1'b1;
      load_byte_i  = 8'hC0 + 8'(i);
      step();
    end
    load_byte_i = 8'hC3;
    rst = 1'b1;
    #1;
    chk("midrst_ready", load_ready_o, 1'b0);
    chk("midrst_cpurst", cpu_rst_o, 1'b1);
    step();
    rst = 1'b0;
    load_valid_i = 1'b0;
    #1;
    chk("midrst_idle", cpu_rst_o, 1'b0);
    chk("midrst_nodone", load_done_o, 1'b0);
    step();
    chk("midrst_nodone2", load_done_o, 1'b0);
    mem_read_i = 1'b1;
    mem_addr_i = 32'h200;
    #1;
    chk("midrst_kept", mem_data_o, 32'hA0C2C1C0);
    mem_addr_i = 32'h204;
    #1;
    chk("midrst_rest", mem_data_o, 32'hB0B1B2B3);
    mem_read_i = 1'b0;

    // top-of-memory bytes, then out-of-range write
    ld_start(12'(DEPTH-3), 13'd3);
    for (int i = 0; i < 3; i++) begin
      load_valid_i = 1'b1;
      load_byte_i  = 8'h77 + 8'(17*i);
      step();
    end
    load_valid_i = 1'b0;
    step();
    chk("top_err_clear", mem_err_o, 1'b0);
    mem_write_i = 1'b1;
    mem_addr_i  = 32'(DEPTH-2);
    mem_data_i  = 32'hFFFFFFFF;
    #1;
    chk("oor_err_before", mem_err_o, 1'b0);
    step();
    mem_write_i = 1'b0;
    chk("oor_err_set", mem_err_o, 1'b1);
    rom_addr_i = 32'(DEPTH-3);
    #1;
    chk("oor_fetch", rom_data_o, 48'h778899000000);
    mem_read_i = 1'b1;
    mem_addr_i = 32'(DEPTH-2);
    #1;
    chk("oor_rd", mem_data_o, 32'h0);
    mem_addr_i = 32'h1000_0100;
    #1;
    chk("oor_rd_upper", mem_data_o, 32'h0);
    mem_read_i = 1'b0;
    rom_addr_i = 32'(DEPTH);
    #1;
    chk("oor_fetch_top", rom_data_o, 48'h0);
    step();
    step();
    chk("err_sticky", mem_err_o, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("err_cleared", mem_err_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
